// File: rtl/uart2sample_multi.sv
// Assembles consecutive UART bytes into BYTES-wide samples tagged with a rotating channel index.
// A partial sample set left idle for TIMEOUT_CYCLES is discarded and the stream resyncs to channel 0.
module uart2sample_multi #(
    parameter int BYTES          = 3,
    parameter int CHANNELS       = 2,
    parameter int MSB_FIRST      = 0,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int CW            = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 in_clk,
    input  logic                 in_rst,
    input  logic                 in_uart_ready,
    input  logic [7:0]           in_uart_frame,
    output logic [8*BYTES-1:0]   out_frame,
    output logic [CW-1:0]        out_channel,
    output logic                 out_ready,
    output logic                 out_last,
    output logic                 out_error
);

    localparam int BW = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int GW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [BW-1:0] BLAST = BW'(BYTES - 1);
    localparam logic [CW-1:0] CLAST = CW'(CHANNELS - 1);
    localparam logic [GW-1:0] TO_LAST = GW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic [CW-1:0]        ccnt_q, ccnt_d;
    logic [8*BYTES-1:0]   asm_q, asm_d;
    logic [GW-1:0]        gap_q, gap_d;
    logic [8*BYTES-1:0]   frame_q, frame_d;
    logic [CW-1:0]        channel_q, channel_d;
    logic                 ready_q, ready_d;
    logic                 last_q, last_d;
    logic                 error_q, error_d;

    logic [8*BYTES-1:0]   asmMerged;
    logic                 active;
    int                   lane;

    always_comb begin
        lane      = (MSB_FIRST != 0) ? (BYTES - 1 - int'(bcnt_q)) : int'(bcnt_q);
        asmMerged = asm_q;
        for (int i = 0; i < BYTES; i++) begin
            if (lane == i) begin
                asmMerged[8*i +: 8] = in_uart_frame;
            end
        end
    end

    assign active = (bcnt_q != '0) || (ccnt_q != '0);

    // A strobe always wins over a timeout that would expire in the same cycle.
    always_comb begin
        bcnt_d    = bcnt_q;
        ccnt_d    = ccnt_q;
        asm_d     = asm_q;
        gap_d     = gap_q;
        frame_d   = frame_q;
        channel_d = channel_q;
        ready_d   = 1'b0;
        last_d    = 1'b0;
        error_d   = 1'b0;
        if (in_uart_ready) begin
            gap_d = '0;
            if (bcnt_q == BLAST) begin
                frame_d   = asmMerged;
                channel_d = ccnt_q;
                ready_d   = 1'b1;
                last_d    = (ccnt_q == CLAST);
                bcnt_d    = '0;
                ccnt_d    = (ccnt_q == CLAST) ? '0 : ccnt_q + CW'(1);
            end else begin
                asm_d  = asmMerged;
                bcnt_d = bcnt_q + BW'(1);
            end
        end else if (active) begin
            if (TO_EN && (gap_q == TO_LAST)) begin
                bcnt_d  = '0;
                ccnt_d  = '0;
                gap_d   = '0;
                error_d = 1'b1;
            end else begin
                gap_d = gap_q + GW'(1);
            end
        end else begin
            gap_d = '0;
        end
    end

    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            bcnt_q    <= '0;
            ccnt_q    <= '0;
            asm_q     <= '0;
            gap_q     <= '0;
            frame_q   <= '0;
            channel_q <= '0;
            ready_q   <= 1'b0;
            last_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            bcnt_q    <= bcnt_d;
            ccnt_q    <= ccnt_d;
            asm_q     <= asm_d;
            gap_q     <= gap_d;
            frame_q   <= frame_d;
            channel_q <= channel_d;
            ready_q   <= ready_d;
            last_q    <= last_d;
            error_q   <= error_d;
        end
    end

    assign out_frame   = frame_q;
    assign out_channel = channel_q;
    assign out_ready   = ready_q;
    assign out_last    = last_q;
    assign out_error   = error_q;

endmodule

// File: doc/uart2sample_multi.md
# uart2sample_multi

Parametrised successor to the single-channel UART sample assembler. It collects consecutive 8-bit UART bytes into samples of `BYTES` bytes each, with a selectable byte order, and tags each sample with a channel index that rotates over `CHANNELS` interleaved channels. An inter-byte timeout discards partial samples and resynchronises to channel 0. It sits between the UART receiver and the per-channel sample processing / DAC path.

## Interface
- `BYTES`, default 3: bytes per sample, range 1..4; the sample width is `8*BYTES`.
- `CHANNELS`, default 2: number of interleaved channels, range 1..8.
- `MSB_FIRST`, default 0: 0 means the first byte received is bits [7:0]; 1 means the first byte received is the most significant byte.
- `TIMEOUT_CYCLES`, default 100000: idle cycles before a partial frame set is discarded; 0 disables the timeout.
- `CW`, localparam: `max(1, clog2(CHANNELS))`.

Ports (clock and reset first):
- `in_clk`  in  1  sole clock; all logic on its rising edge.
- `in_rst`  in  1  reset, asynchronous, active-high.
- `in_uart_ready`  in  1  one-cycle strobe; `in_uart_frame` is valid in that cycle.
- `in_uart_frame`  in  8  received byte.
- `out_frame`  out  `8*BYTES`  last completed sample; held until the next completion.
- `out_channel`  out  `CW`  channel index of `out_frame`.
- `out_ready`  out  1  one-cycle pulse when `out_frame` / `out_channel` update.
- `out_last`  out  1  pulses together with `out_ready` when `out_channel == CHANNELS-1`.
- `out_error`  out  1  one-cycle pulse when a timeout discards partial data.

## Operation
- **State:**
  - byte counter `bcnt`, range 0..BYTES-1
  - channel counter `ccnt`, range 0..CHANNELS-1
  - assembly register `asm`, width `8*BYTES`
  - gap counter, sized to hold `TIMEOUT_CYCLES`
- **Byte placement:**
  - `MSB_FIRST=0`: the byte lands in `asm[8*bcnt +: 8]`.
  - `MSB_FIRST=1`: the byte lands in `asm[8*(BYTES-1-bcnt) +: 8]`.
- **Strobe handling:**
  - On a strobe with `bcnt < BYTES-1`: store the byte, then `bcnt++`.
  - On a strobe with `bcnt == BYTES-1`:
    - `out_frame` <= `asm` with the final byte merged in.
    - `out_channel` <= `ccnt`.
    - `out_ready` <= 1.
    - `out_last` <= (`ccnt == CHANNELS-1`).
    - `bcnt` <= 0.
    - `ccnt` wraps: `CHANNELS-1` goes to 0, otherwise `ccnt + 1`.
- **Output stability:** `out_frame` changes only on completion. Partial bytes never appear on it; this differs from the predecessor, which updated its output in place.
- **Flag deassertion:** `out_ready`, `out_last` and `out_error` are registered and deassert the following cycle unless re-asserted.
- **Gap counter:**
  - Cleared on every strobe.
  - When `bcnt != 0 || ccnt != 0` and there is no strobe, it increments.
  - When `bcnt == 0 && ccnt == 0`, it is held at 0.
- **Timeout:**
  - Fires when the gap counter equals `TIMEOUT_CYCLES-1` and there is no strobe that cycle.
  - Action: `bcnt` <= 0, `ccnt` <= 0, gap counter <= 0, `out_error` <= 1.
  - `asm` contents are don't-care; `out_frame` and `out_channel` are untouched.
- **Degenerate cases:**
  - `BYTES=1`: every strobe completes a sample.
  - `CHANNELS=1`: `out_channel` stays 0 and `out_last` pulses with every `out_ready`.

## Timing
- **Reset** (asynchronous, immediate): `out_frame=0`, `out_channel=0`, `out_ready=0`, `out_last=0`, `out_error=0`; `bcnt`, `ccnt`, gap counter and `asm` all 0.
- **Reset mid-sample:** partial data is lost. After release, the first strobe is byte 0 of channel 0.
- **Latency:** `out_ready` is high in cycle N+1 for a final-byte strobe in cycle N; `out_frame` is valid in that same cycle.
- **Strobe rate:**
  - Strobes may arrive on consecutive cycles; each is accepted, and there is no backpressure.
  - A final-byte strobe followed by a strobe the next cycle starts the next sample while `out_ready` is high.
- **Timeout timing:**
  - With the last strobe in cycle N, `out_error` is high in cycle N+TIMEOUT_CYCLES+1.
  - A strobe in the expiry cycle wins: the byte is accepted and there is no timeout.
- **No timeout when idle:** an idle link after a complete frame set (`bcnt=0`, `ccnt=0`) never raises `out_error`.

## Test plan
- **Basic ordering**, `BYTES=3`, `CHANNELS=2`, `MSB_FIRST=0`:
  - Stimulus: strobes with 0x11, 0x22, 0x33, 0x44, 0x55, 0x66.
  - Required: `out_frame=0x332211` / `out_channel=0` / `out_last=0`, then `out_frame=0x665544` / `out_channel=1` / `out_last=1`.
  - Required: each `out_ready` is exactly one cycle, one cycle after the third byte of its sample.
- **Byte order**, `MSB_FIRST=1`, `BYTES=2`, `CHANNELS=1`:
  - Stimulus: bytes 0xAB, 0xCD.
  - Required: `out_frame=0xABCD`, `out_channel=0`, `out_last=1`.
- **Back-to-back strobes**, `BYTES=3`, `CHANNELS=2`:
  - Stimulus: 12 strobes on consecutive cycles.
  - Required: 4 `out_ready` pulses, `out_channel` sequence 0, 1, 0, 1, no `out_error`, correct data in each.
- **Timeout**, `TIMEOUT_CYCLES=16`:
  - Stimulus: 2 bytes, then idle.
  - Required: `out_error` pulses 17 cycles after the last strobe and `out_frame` is unchanged.
  - Required: the next 3 bytes 0x01, 0x02, 0x03 give `out_frame=0x030201` with `out_channel=0`.
  - Required: a strobe in the 16th idle cycle suppresses the error.
- **Reset mid-operation:**
  - Stimulus: assert `in_rst` after channel 0 completes and 1 byte of channel 1 has arrived.
  - Required: all outputs go to 0 immediately.
  - Required: after release, 3 bytes produce `out_channel=0`.
- **Idle after complete set:**
  - Stimulus: complete 2 channels, then 1000 idle cycles with `TIMEOUT_CYCLES=16`.
  - Required: no `out_error`, and the outputs hold their last values.
